// File: rtl/sd_block_read_ctrl_if.sv
// Host, command-engine, SD pin and FIFO signals of the SPI-mode SD block reader.
// master = reader controller, slave = host/command engine/card/FIFO side.
interface sd_block_read_ctrl_if;
    logic        start;
    logic [31:0] start_block;
    logic [9:0]  block_count;
    logic        busy;
    logic        done;
    logic        error;
    logic [2:0]  err_code;
    logic        cmd_start;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        cmd_finish;
    logic [7:0]  cmd_resp;
    logic        do_in;
    logic        cs;
    logic        di;
    logic        sclk_en;
    logic [7:0]  fo_data;
    logic        fo_we;
    logic        fo_busy;

    modport master (
        input  start, start_block, block_count, cmd_finish, cmd_resp, do_in, fo_busy,
        output busy, done, error, err_code, cmd_start, cmd_index, cmd_arg,
               cs, di, sclk_en, fo_data, fo_we
    );

    modport slave (
        output start, start_block, block_count, cmd_finish, cmd_resp, do_in, fo_busy,
        input  busy, done, error, err_code, cmd_start, cmd_index, cmd_arg,
               cs, di, sclk_en, fo_data, fo_we
    );
endinterface

// File: rtl/sd_block_read_ctrl.sv
// SPI-mode SD multi-block reader issuing one CMD17 per block into a byte FIFO.
// Define SD_READ_CRC_EN to verify the CRC16 of every data block.
module sd_block_read_ctrl #(
    parameter bit BYTE_ADDR     = 1'b0,
    parameter int TOKEN_TIMEOUT = 1023,
    parameter int GAP_BITS      = 8
) (
    input logic clk,
    input logic reset,
    sd_block_read_ctrl_if.master bus
);
    typedef enum logic [3:0] {IDLE, ISSUE, WAIT_R1, TOKEN, DATA, CRC, GAP, DONE, ERR} state_t;

    state_t      state;
    logic [31:0] blkReg;
    logic [9:0]  remainingReg;
    logic [9:0]  tokenCnt;
    logic [8:0]  byteCnt;
    logic [3:0]  bitCnt;
    logic [15:0] gapCnt;
    logic [7:0]  shiftReg;
    logic        stallReg;
    logic        busyReg, doneReg, errorReg, cmdStartReg, csReg, sclkEnReg, foWeReg;
    logic [2:0]  errCodeReg;
    logic [7:0]  foDataReg;
    logic [7:0]  byteNext;

    assign byteNext = {shiftReg[6:0], bus.do_in};

`ifdef SD_READ_CRC_EN
    logic [15:0] crcCalc;
    logic [15:0] crcRx;
    logic [15:0] crcStep;
    assign crcStep = {crcCalc[14:0], 1'b0} ^ ((crcCalc[15] ^ bus.do_in) ? 16'h1021 : 16'h0000);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            blkReg       <= '0;
            remainingReg <= '0;
            tokenCnt     <= '0;
            byteCnt      <= '0;
            bitCnt       <= '0;
            gapCnt       <= '0;
            shiftReg     <= '0;
            stallReg     <= 1'b0;
            busyReg      <= 1'b0;
            doneReg      <= 1'b0;
            errorReg     <= 1'b0;
            errCodeReg   <= '0;
            cmdStartReg  <= 1'b0;
            csReg        <= 1'b1;
            sclkEnReg    <= 1'b1;
            foWeReg      <= 1'b0;
            foDataReg    <= '0;
`ifdef SD_READ_CRC_EN
            crcCalc      <= '0;
            crcRx        <= '0;
`endif
        end else begin
            doneReg     <= 1'b0;
            errorReg    <= 1'b0;
            cmdStartReg <= 1'b0;
            foWeReg     <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.block_count == 10'd0) begin
                            state      <= ERR;
                            errorReg   <= 1'b1;
                            errCodeReg <= 3'd5;
                        end else begin
                            state        <= ISSUE;
                            blkReg       <= bus.start_block;
                            remainingReg <= bus.block_count;
                            busyReg      <= 1'b1;
                            errCodeReg   <= 3'd0;
                            csReg        <= 1'b0;
                            cmdStartReg  <= 1'b1;
                        end
                    end
                end
                ISSUE: state <= WAIT_R1;
                WAIT_R1: begin
                    if (bus.cmd_finish) begin
                        if (bus.cmd_resp == 8'h00) begin
                            state    <= TOKEN;
                            tokenCnt <= '0;
                            bitCnt   <= '0;
                        end else begin
                            state      <= ERR;
                            errorReg   <= 1'b1;
                            errCodeReg <= 3'd1;
                            busyReg    <= 1'b0;
                            csReg      <= 1'b1;
                            sclkEnReg  <= 1'b1;
                        end
                    end
                end
                TOKEN: begin
                    shiftReg <= byteNext;
                    if (bitCnt[2:0] == 3'd7) begin
                        bitCnt <= '0;
                        if (byteNext == 8'hFE) begin
                            state   <= DATA;
                            byteCnt <= '0;
`ifdef SD_READ_CRC_EN
                            crcCalc <= '0;
`endif
                        end else if (byteNext == 8'hFF && tokenCnt != 10'(TOKEN_TIMEOUT - 1)) begin
                            tokenCnt <= tokenCnt + 10'd1;
                        end else begin
                            state      <= ERR;
                            errorReg   <= 1'b1;
                            errCodeReg <= (byteNext == 8'hFF) ? 3'd3 : 3'd2;
                            busyReg    <= 1'b0;
                            csReg      <= 1'b1;
                            sclkEnReg  <= 1'b1;
                        end
                    end else begin
                        bitCnt <= bitCnt + 4'd1;
                    end
                end
                DATA: begin
                    // While stalled the card clock is gated, so only the pending write can advance.
                    if (stallReg) begin
                        if (!bus.fo_busy) begin
                            foWeReg   <= 1'b1;
                            stallReg  <= 1'b0;
                            sclkEnReg <= 1'b1;
                            byteCnt   <= byteCnt + 9'd1;
                            if (byteCnt == 9'd511) state <= CRC;
                        end
                    end else begin
                        shiftReg <= byteNext;
`ifdef SD_READ_CRC_EN
                        crcCalc  <= crcStep;
`endif
                        if (bitCnt[2:0] == 3'd7) begin
                            bitCnt    <= '0;
                            foDataReg <= byteNext;
                            if (bus.fo_busy) begin
                                stallReg  <= 1'b1;
                                sclkEnReg <= 1'b0;
                            end else begin
                                foWeReg <= 1'b1;
                                byteCnt <= byteCnt + 9'd1;
                                if (byteCnt == 9'd511) state <= CRC;
                            end
                        end else begin
                            bitCnt <= bitCnt + 4'd1;
                        end
                    end
                end
                CRC: begin
`ifdef SD_READ_CRC_EN
                    crcRx <= {crcRx[14:0], bus.do_in};
`endif
                    if (bitCnt == 4'd15) begin
                        bitCnt <= '0;
`ifdef SD_READ_CRC_EN
                        if ({crcRx[14:0], bus.do_in} != crcCalc) begin
                            state      <= ERR;
                            errorReg   <= 1'b1;
                            errCodeReg <= 3'd4;
                            busyReg    <= 1'b0;
                            csReg      <= 1'b1;
                            sclkEnReg  <= 1'b1;
                        end else
`endif
                        begin
                            state        <= GAP;
                            csReg        <= 1'b1;
                            gapCnt       <= '0;
                            remainingReg <= remainingReg - 10'd1;
                            blkReg       <= blkReg + 32'd1;
                        end
                    end else begin
                        bitCnt <= bitCnt + 4'd1;
                    end
                end
                GAP: begin
                    if (gapCnt == 16'(GAP_BITS - 1)) begin
                        if (remainingReg == 10'd0) begin
                            state   <= DONE;
                            doneReg <= 1'b1;
                            busyReg <= 1'b0;
                        end else begin
                            state       <= ISSUE;
                            csReg       <= 1'b0;
                            cmdStartReg <= 1'b1;
                        end
                    end else begin
                        gapCnt <= gapCnt + 16'd1;
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busyReg;
    assign bus.done      = doneReg;
    assign bus.error     = errorReg;
    assign bus.err_code  = errCodeReg;
    assign bus.cmd_start = cmdStartReg;
    assign bus.cmd_index = 6'd17;
    assign bus.cmd_arg   = BYTE_ADDR ? {blkReg[22:0], 9'b0} : blkReg;
    assign bus.cs        = csReg;
    assign bus.di        = 1'b1;
    assign bus.sclk_en   = sclkEnReg;
    assign bus.fo_data   = foDataReg;
    assign bus.fo_we     = foWeReg;
endmodule

// File: doc/sd_block_read_ctrl.md
Name: sd_block_read_ctrl

Overview:
- Sequencer for SPI-mode SD single-block reads (CMD17). Covers a run of consecutive blocks.
- Sits after card init completes, between the host (start/done) and the shared command/response engine, the SD bus pins (CS/DI/DO), and the byte FIFO.
- Issues one CMD17 per block and hunts the 0xFE data token. Shifts 512 data bytes into the FIFO with backpressure, consumes the CRC, and inserts an inter-block gap.

Parameters:
- BYTE_ADDR, 0, 1 = argument is block<<9 (SDSC byte addressing); 0 = argument is block number (SDHC).
- TOKEN_TIMEOUT, 1023, max 0xFF bytes tolerated before the data token; width 10 bits.
- GAP_BITS, 8, idle clocks with CS high between blocks.

Ports:
- clk  in  1  system clock; equals SCLK while this block owns the bus.
- reset  in  1  synchronous, active-high.
- start  in  1  1-cycle request; sampled only in IDLE.
- start_block  in  32  first block number.
- block_count  in  10  number of blocks; 0 is illegal.
- busy  out  1  high from start-accept until DONE/ERR exit.
- done  out  1  1-cycle pulse on successful completion.
- error  out  1  1-cycle pulse on abort.
- err_code  out  3  holds last error until next start: 1 R1!=0, 2 error token, 3 token timeout, 4 CRC fail, 5 bad count.
- cmd_start  out  1  1-cycle pulse to command engine.
- cmd_index  out  6  constant 17 while busy.
- cmd_arg  out  32  block address.
- cmd_finish  in  1  command engine R1 received.
- cmd_resp  in  8  R1 byte, valid with cmd_finish.
- do_in  in  1  card DO.
- cs  out  1  card select, active-low.
- di  out  1  card DI; held 1 whenever the command engine is not driving.
- sclk_en  out  1  SCLK gate; 0 stalls the card clock.
- fo_data  out  8  FIFO write data.
- fo_we  out  1  FIFO write strobe, 1 cycle.
- fo_busy  in  1  FIFO full/backpressure.

Behaviour:
- Reset values: state=IDLE; busy=0; done=0; error=0; err_code=0; cmd_start=0; cs=1; di=1; sclk_en=1; fo_we=0; fo_data=0; all counters=0.
- Reset mid-operation: forces IDLE next cycle with all outputs at reset values. No FIFO write occurs in the reset cycle.
- States: IDLE, ISSUE, WAIT_R1, TOKEN, DATA, CRC, GAP, DONE, ERR.
- IDLE
  - start with block_count=0 -> ERR, code 5.
  - Otherwise latch blk=start_block, remaining=block_count, set busy=1 -> ISSUE.
- ISSUE
  - cs=0, cmd_arg = BYTE_ADDR ? {blk[22:0],9'b0} : blk.
  - cmd_start=1 for exactly one cycle -> WAIT_R1.
- WAIT_R1
  - On cmd_finish: cmd_resp==0x00 -> TOKEN (byte counter cleared); otherwise -> ERR, code 1.
- TOKEN
  - Shift do_in MSB-first, 8 clocks per byte.
  - 0xFF -> count++; count reaching TOKEN_TIMEOUT -> ERR, code 3.
  - 0xFE -> DATA.
  - Any other byte -> ERR, code 2.
- DATA
  - 512 bytes, MSB-first. On byte completion present fo_data and pulse fo_we if fo_busy=0.
  - If fo_busy=1 at byte completion: hold the byte and drive sclk_en=0 (no DO sampling, bit counter frozen). Write in the first cycle fo_busy=0, then set sclk_en=1.
  - Exactly 512 fo_we pulses per block, never 2 in consecutive cycles without an intervening byte.
  - After byte 511 -> CRC.
- CRC: 16 clocks shifting into crc_rx -> GAP.
- GAP
  - cs=1, di=1 for GAP_BITS clocks; remaining--, blk++ (32-bit wrap permitted).
  - remaining==0 -> DONE; otherwise -> ISSUE.
- DONE: done=1 one cycle, busy=0, cs=1 -> IDLE.
- ERR: error=1 one cycle, err_code set, busy=0, cs=1, sclk_en=1 -> IDLE.
- start while busy is ignored. cmd_finish outside WAIT_R1 is ignored.

Optional Feature:
- Macro SD_READ_CRC_EN.
- When defined: CRC16-CCITT (poly 0x1021, init 0) is computed bitwise over the 4096 data bits. At CRC exit, mismatch with crc_rx -> ERR, code 4; data already written to the FIFO is not retracted.
- When undefined: crc_rx is discarded and code 4 never occurs.

Test Plan:
- start_block=5, count=1, BYTE_ADDR=0, R1=0x00, 3×0xFF then 0xFE, data=i[7:0], fo_busy=0 -> cmd_arg=5, 512 fo_we with values 0..255,0..255, then done pulse, busy low, cs high.
- BYTE_ADDR=1, start_block=2, count=3 -> cmd_arg 0x400, 0x600, 0x800. Between blocks cs=1 for 8 clocks; 1536 writes, one done.
- R1=0x04 -> error pulse, err_code=1, no fo_we, cs=1. Token byte 0x09 -> err_code=2. 1023×0xFF -> err_code=3.
- fo_busy held 1 for 20 cycles at byte 100 -> sclk_en=0 for those cycles, byte 100 written once, bytes 101..511 intact, total 512 writes.
- reset asserted at byte 300 -> next cycle IDLE, busy=0, cs=1. New start completes a full clean block.
- SD_READ_CRC_EN with corrupted CRC -> 512 writes then error with err_code=4. Correct CRC -> done. count=0 -> err_code=5 immediately.
